// File: rtl/if_id_buf_pkg.sv
// Shared constants and the queue-operation encoding for the IF/ID instruction queue.
// Holds the NOP, zero and no-interrupt defaults plus the default queue depth.
package if_id_buf_pkg;

  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
  localparam logic [7:0]  INT_NONE    = 8'h00;
  localparam int          IF_ID_DEPTH = 2;

  typedef enum logic [1:0] {
    Q_IDLE = 2'b00,
    Q_PUSH = 2'b01,
    Q_POP  = 2'b10,
    Q_BOTH = 2'b11
  } q_op_e;

  function automatic q_op_e q_op(input logic push, input logic pop);
    q_op_e op;
    case ({pop, push})
      2'b01:   op = Q_PUSH;
      2'b10:   op = Q_POP;
      2'b11:   op = Q_BOTH;
      default: op = Q_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/if_id_buf_mem.sv
// Un-reset register array for the IF/ID queue: one synchronous write port,
// one asynchronous read port.
module if_id_buf_mem
  import if_id_buf_pkg::*;
#(
  parameter int DEPTH = IF_ID_DEPTH,
  parameter int WIDTH = 72,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_buf.sv
// Fetch-to-decode instruction queue: DEPTH entries of {inst, addr, int flag}
// with valid/ready on both sides, flush and occupancy count.
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int                DEPTH    = IF_ID_DEPTH,
  parameter int                INST_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                INT_W    = 8,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(INST_NOP)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [INST_W-1:0]          inst_i,
  input  logic [ADDR_W-1:0]          inst_addr_i,
  input  logic [INT_W-1:0]           int_flag_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [INST_W-1:0]          inst_o,
  output logic [ADDR_W-1:0]          inst_addr_o,
  output logic [INT_W-1:0]           int_flag_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ENT_W = INST_W + ADDR_W + INT_W;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             push;
  logic             pop;
  logic             mem_we;
  q_op_e            op;
  logic [ENT_W-1:0] wr_entry;
  logic [ENT_W-1:0] rd_entry;
  logic [INST_W-1:0] rd_inst;
  logic [ADDR_W-1:0] rd_addr;
  logic [INT_W-1:0]  rd_flag;

  // Handshakes depend only on registered count, so out_ready_i never reaches in_ready_o.
  assign in_ready_o  = (count < CNT_W'(DEPTH));
  assign out_valid_o = (count != '0);
  assign count_o     = count;

  assign push   = in_valid_i & in_ready_o;
  assign pop    = out_valid_o & out_ready_i;
  assign mem_we = push & ~flush_i;
  assign op     = q_op(push, pop);

  assign wr_entry = {inst_i, inst_addr_i, int_flag_i};
  assign {rd_inst, rd_addr, rd_flag} = rd_entry;

  if_id_buf_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // pointer and occupancy update; flush outranks any handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (op)
        Q_PUSH: begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          count  <= count + CNT_W'(1);
        end
        Q_POP: begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          count  <= count - CNT_W'(1);
        end
        Q_BOTH: begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        Q_IDLE: begin
          wr_ptr <= wr_ptr;
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

  // head presentation; an empty queue shows a NOP so decode sees a bubble
  always_comb begin
    inst_o      = NOP_INST;
    inst_addr_o = ADDR_W'(ZERO_WORD);
    int_flag_o  = INT_W'(INT_NONE);
    if (out_valid_o) begin
      inst_o      = rd_inst;
      inst_addr_o = rd_addr;
      int_flag_o  = rd_flag;
    end else begin
      inst_o      = NOP_INST;
      inst_addr_o = ADDR_W'(ZERO_WORD);
      int_flag_o  = INT_W'(INT_NONE);
    end
  end

endmodule

// File: tb/tb_if_id_buf.sv
// Scoreboard bench for if_id_buf: accepted entries are queued by the stimulus,
// a negedge monitor checks the head/count against the queue and retires pops.
module tb_if_id_buf;

  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [7:0]  flag;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic [7:0]  int_flag;
  logic out_valid;
  logic out_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_addr_out;
  logic [7:0]  int_flag_out;
  logic [CNT_W-1:0] count;

  ent_t exp_q[$];
  bit   pend = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  if_id_buf #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .inst_i      (inst),
    .inst_addr_i (inst_addr),
    .int_flag_i  (int_flag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .inst_o      (inst_out),
    .inst_addr_o (inst_addr_out),
    .int_flag_o  (int_flag_out),
    .count_o     (count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs; an entry the queue can take is scoreboarded now.
  task automatic cycle(input logic v, input logic [31:0] i, input logic [31:0] a,
                       input logic [7:0] f, input logic ordy, input logic fl);
    ent_t e;
    @(posedge clk);
    #1;
    in_valid  = v;
    inst      = i;
    inst_addr = a;
    int_flag  = f;
    out_ready = ordy;
    flush     = fl;
    pend      = 1'b0;
    if (v && !fl && !rst && exp_q.size() < DEPTH) begin
      e.inst = i;
      e.addr = a;
      e.flag = f;
      exp_q.push_back(e);
      pend = 1'b1;
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 32'h0, 32'h0, 8'h0, ordy, 1'b0);
  endtask

  // Monitor: compare visible state, then retire the entry decode consumes.
  always @(negedge clk) begin
    int   vis;
    ent_t h;
    vis = exp_q.size() - (pend ? 1 : 0);
    chk("count", 64'(count), 64'(vis));
    chk("out_valid", 64'(out_valid), 64'(vis != 0));
    chk("in_ready", 64'(in_ready), 64'(vis < DEPTH));
    if (vis != 0) begin
      h = exp_q[0];
      chk("head_inst", 64'(inst_out), 64'(h.inst));
      chk("head_addr", 64'(inst_addr_out), 64'(h.addr));
      chk("head_flag", 64'(int_flag_out), 64'(h.flag));
    end else begin
      chk("nop_inst", 64'(inst_out), 64'h13);
      chk("nop_addr", 64'(inst_addr_out), 64'h0);
      chk("nop_flag", 64'(int_flag_out), 64'h0);
    end
    if (!rst) begin
      if (flush) begin
        exp_q.delete();
      end else if (out_ready && vis != 0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inst = 32'h0; inst_addr = 32'h0; int_flag = 8'h0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h1);
    chk("rst_inst", 64'(inst_out), 64'h13);
    chk("rst_count", 64'(count), 64'h0);

    // pass-through
    cycle(1'b1, 32'h00500093, 32'h100, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 32'h00a00113, 32'h104, 8'h00, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // stall until full, third entry dropped, then drain
    cycle(1'b1, 32'h00500093, 32'h100, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 32'h00a00113, 32'h104, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 32'h00f00193, 32'h108, 8'h00, 1'b0, 1'b0);
    idle(1'b0);
    #1 chk("full_count", 64'(count), 64'h2);
    chk("full_ready", 64'(in_ready), 64'h0);
    repeat (3) idle(1'b1);

    // full with pop, then push+pop wrapping the pointers
    cycle(1'b1, 32'h11111111, 32'h200, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 32'h22222222, 32'h204, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 32'h33333333, 32'h208, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 32'h44444444, 32'h20c, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 32'h55555555, 32'h210, 8'h00, 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    // flush while full with a colliding push
    cycle(1'b1, 32'h66666666, 32'h300, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 32'h77777777, 32'h304, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 32'hdeadbeef, 32'h308, 8'h00, 1'b1, 1'b1);
    idle(1'b1);
    #1 chk("flush_count", 64'(count), 64'h0);
    chk("flush_inst", 64'(inst_out), 64'h13);
    idle(1'b1);

    // interrupt flags stay with their entries
    cycle(1'b1, 32'h00100073, 32'h400, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000013, 32'h404, 8'h00, 1'b0, 1'b0);
    repeat (3) idle(1'b1);

    // asynchronous reset between edges with one entry held
    cycle(1'b1, 32'h00200093, 32'h500, 8'h00, 1'b0, 1'b0);
    idle(1'b0);
    #2 rst = 1'b1;
    #1 chk("arst_valid", 64'(out_valid), 64'h0);
    chk("arst_count", 64'(count), 64'h0);
    exp_q.delete();
    pend = 1'b0;
    idle(1'b1);
    #2 rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(3, 0) != 0, $urandom, $urandom & 32'hffff_fffc,
            8'($urandom_range(255, 0)), $urandom_range(1, 0) == 1,
            $urandom_range(15, 0) == 0);
    end
    repeat (4) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
